lockout_ctrl: RTL and testbench
===============================

// Module: lockout_ctrl
// PURPOSE
//  Attempt/lockout supervisor driving the lockout timer's start input and consuming its busy
//  (dis) and timeout (reset) outputs. Counts wrong code entries; after MAX_TRIES failures it
//  arms the timer and holds the lock closed until the timeout pulse returns. It latches a
//  sticky alarm after MAX_LOCKOUTS consecutive lockouts. Sits between code comparator and timer.
// PARAMETERS
//  MAX_TRIES    3  wrong entries that trigger a lockout (>=1)
//  MAX_LOCKOUTS 2  consecutive lockouts that trigger alarm (>=1)
//  ACK_WAIT     4  cycles allowed for timer_busy to rise after start is raised (>=2)
//  CW           4  width of fail_cnt/lock_cnt; 2**CW > max(MAX_TRIES,MAX_LOCKOUTS)
// PORTS
//  clk          in  1   clock, rising edge
//  rst          in  1   reset, asynchronous, active-low
//  entry_valid  in  1   1-cycle pulse: user submitted a code
//  entry_ok     in  1   code matched; qualified by entry_valid
//  admin_clr    in  1   1-cycle pulse: clear alarm/fault, return to READY
//  timer_busy   in  1   timer dis output (1 while counting)
//  timer_done   in  1   timer reset output (1-cycle timeout pulse)
//  timer_start  out 1   start request to timer
//  locked       out 1   1 in ARM, LOCKED, ALARM
//  grant        out 1   1-cycle pulse: correct code accepted
//  deny         out 1   1-cycle pulse: wrong code counted
//  reject       out 1   1-cycle pulse: entry_valid ignored (not READY)
//  alarm        out 1   1 in ALARM
//  fault        out 1   sticky: timer failed to acknowledge start
//  fail_cnt     out CW  wrong entries since last grant/lockout
//  lock_cnt     out CW  consecutive lockouts since last grant
// BEHAVIOUR
//  Reset: state=READY. All outputs 0, counters 0. Every output is registered.
//  Pulse outputs are asserted on the cycle after the causing input is sampled.
//  READY:
//   - entry_valid&entry_ok: grant=1; fail_cnt=0; lock_cnt=0; stay.
//   - entry_valid&!entry_ok, fail_cnt+1<MAX_TRIES: deny=1; fail_cnt++; stay.
//   - entry_valid&!entry_ok, fail_cnt+1==MAX_TRIES: deny=1; fail_cnt=0; lock_cnt++.
//     If lock_cnt+1==MAX_LOCKOUTS go ALARM; else go ARM.
//  ARM: timer_start=1 (level) and ack counter starts at 0.
//   - timer_busy=1: timer_start=0 next cycle; go LOCKED.
//   - ACK_WAIT cycles without busy: timer_start=0, fault=1; go ALARM.
//  LOCKED: timer_start=0; wait.
//   - timer_done=1: go READY. locked drops the next cycle.
//   - timer_busy falls without timer_done: treat as done and go READY.
//  ALARM: alarm=1, locked=1. Only admin_clr exits: go READY, clear fail_cnt, lock_cnt,
//    alarm and fault.
//  admin_clr in READY/ARM/LOCKED: ignored (no counter change).
//  entry_valid in ARM/LOCKED/ALARM: reject=1; counters unchanged; entry_ok ignored.
//  entry_valid and timer_done in the same LOCKED cycle: reject=1 and go READY.
//    The entry is not counted.
//  Counters saturate and never wrap. lock_cnt is cleared only by grant, admin_clr or rst.
//  Reset mid-operation (any state): immediate return to reset values. timer_start drops
//    asynchronously.
//  Illegal state encoding: recover to READY with counters cleared.
// TESTING  (MAX_TRIES=3, MAX_LOCKOUTS=2, ACK_WAIT=4; timer model acks 1 cycle after start)
//  1. Two wrong entries, then one right entry -> deny x2 (fail_cnt 1,2); grant=1;
//     fail_cnt=0; locked never 1.
//  2. Three wrong entries -> third deny plus state ARM, timer_start=1 for 1 cycle;
//     locked=1; lock_cnt=1. On timer_done pulse, locked=0 next cycle.
//  3. Entry while LOCKED -> reject=1, fail_cnt stays 0. Entry on the same cycle as
//     timer_done -> reject=1 and state READY.
//  4. Two full lockout cycles with no grant -> 6th wrong entry enters ALARM directly,
//     alarm=1, no timer_start. admin_clr -> alarm=0, lock_cnt=0.
//  5. Timer model never raises busy -> timer_start high exactly 4 cycles; then fault=1
//     and alarm=1.
//  6. rst low while in ARM -> timer_start=0, locked=0, counters 0 with no clock edge.

Source files
------------

// File: rtl/lockout_ctrl_if.sv
// Bundle between the lockout supervisor, the code comparator, the lockout timer and the admin input.
interface lockout_ctrl_if #(
    parameter int CW = 4
);
    logic          entry_valid;
    logic          entry_ok;
    logic          admin_clr;
    logic          timer_busy;
    logic          timer_done;
    logic          timer_start;
    logic          locked;
    logic          grant;
    logic          deny;
    logic          reject;
    logic          alarm;
    logic          fault;
    logic [CW-1:0] fail_cnt;
    logic [CW-1:0] lock_cnt;

    modport master (
        output entry_valid, entry_ok, admin_clr, timer_busy, timer_done,
        input  timer_start, locked, grant, deny, reject, alarm, fault, fail_cnt, lock_cnt
    );

    modport slave (
        input  entry_valid, entry_ok, admin_clr, timer_busy, timer_done,
        output timer_start, locked, grant, deny, reject, alarm, fault, fail_cnt, lock_cnt
    );
endinterface

// File: rtl/lockout_ctrl.sv
// Attempt/lockout supervisor: counts wrong codes, arms the lockout timer, raises a sticky alarm
// after repeated lockouts or when the timer never acknowledges its start request.
module lockout_ctrl #(
    parameter int MAX_TRIES    = 3,
    parameter int MAX_LOCKOUTS = 2,
    parameter int ACK_WAIT     = 4,
    parameter int CW           = 4
) (
    input logic           clk,
    input logic           rst,
    lockout_ctrl_if.slave io_bus
);
    localparam int AW = $clog2(ACK_WAIT);

    typedef enum logic [1:0] {
        S_READY,
        S_ARM,
        S_LOCKED,
        S_ALARM
    } state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_fail_cnt, w_fail_nx;
    logic [CW-1:0] r_lock_cnt, w_lock_nx;
    logic [AW-1:0] r_ack, w_ack_nx;
    logic          r_fault, w_fault_nx;
    logic          r_grant, w_grant_nx;
    logic          r_deny, w_deny_nx;
    logic          r_reject, w_reject_nx;
    logic          r_timer_start, r_locked, r_alarm;
    logic [CW-1:0] w_fail_inc, w_lock_inc;

    assign w_fail_inc = r_fail_cnt + CW'(1);
    assign w_lock_inc = (r_lock_cnt == '1) ? r_lock_cnt : r_lock_cnt + CW'(1);

    always_comb begin
        w_state_nx  = r_state;
        w_fail_nx   = r_fail_cnt;
        w_lock_nx   = r_lock_cnt;
        w_ack_nx    = r_ack;
        w_fault_nx  = r_fault;
        w_grant_nx  = 1'b0;
        w_deny_nx   = 1'b0;
        w_reject_nx = 1'b0;
        case (r_state)
            S_READY: begin
                if (io_bus.entry_valid) begin
                    if (io_bus.entry_ok) begin
                        w_grant_nx = 1'b1;
                        w_fail_nx  = '0;
                        w_lock_nx  = '0;
                    end else begin
                        w_deny_nx = 1'b1;
                        if (w_fail_inc >= CW'(MAX_TRIES)) begin
                            w_fail_nx  = '0;
                            w_lock_nx  = w_lock_inc;
                            w_ack_nx   = '0;
                            w_state_nx = (w_lock_inc >= CW'(MAX_LOCKOUTS)) ? S_ALARM : S_ARM;
                        end else begin
                            w_fail_nx = w_fail_inc;
                        end
                    end
                end
            end
            S_ARM: begin
                w_reject_nx = io_bus.entry_valid;
                if (io_bus.timer_busy) begin
                    w_state_nx = S_LOCKED;
                end else if (r_ack == AW'(ACK_WAIT - 1)) begin
                    w_state_nx = S_ALARM;
                    w_fault_nx = 1'b1;
                end else begin
                    w_ack_nx = r_ack + AW'(1);
                end
            end
            S_LOCKED: begin
                w_reject_nx = io_bus.entry_valid;
                // A busy drop without the done pulse still ends the lockout.
                if (io_bus.timer_done || !io_bus.timer_busy) begin
                    w_state_nx = S_READY;
                end
            end
            S_ALARM: begin
                w_reject_nx = io_bus.entry_valid;
                if (io_bus.admin_clr) begin
                    w_state_nx = S_READY;
                    w_fail_nx  = '0;
                    w_lock_nx  = '0;
                    w_fault_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_READY;
                w_fail_nx  = '0;
                w_lock_nx  = '0;
                w_ack_nx   = '0;
                w_fault_nx = 1'b0;
            end
        endcase
    end

    // Level outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_READY;
            r_fail_cnt    <= '0;
            r_lock_cnt    <= '0;
            r_ack         <= '0;
            r_fault       <= 1'b0;
            r_grant       <= 1'b0;
            r_deny        <= 1'b0;
            r_reject      <= 1'b0;
            r_timer_start <= 1'b0;
            r_locked      <= 1'b0;
            r_alarm       <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_fail_cnt    <= w_fail_nx;
            r_lock_cnt    <= w_lock_nx;
            r_ack         <= w_ack_nx;
            r_fault       <= w_fault_nx;
            r_grant       <= w_grant_nx;
            r_deny        <= w_deny_nx;
            r_reject      <= w_reject_nx;
            r_timer_start <= (w_state_nx == S_ARM);
            r_locked      <= (w_state_nx != S_READY);
            r_alarm       <= (w_state_nx == S_ALARM);
        end
    end

    assign io_bus.timer_start = r_timer_start;
    assign io_bus.locked      = r_locked;
    assign io_bus.grant       = r_grant;
    assign io_bus.deny        = r_deny;
    assign io_bus.reject      = r_reject;
    assign io_bus.alarm       = r_alarm;
    assign io_bus.fault       = r_fault;
    assign io_bus.fail_cnt    = r_fail_cnt;
    assign io_bus.lock_cnt    = r_lock_cnt;
endmodule

// File: tb/tb_lockout_ctrl.sv
// Random-stimulus bench for lockout_ctrl with a reactive timer and a rule-level reference model.
module tb_lockout_ctrl;
    localparam int MAX_TRIES    = 3;
    localparam int MAX_LOCKOUTS = 2;
    localparam int ACK_WAIT     = 4;
    localparam int CW           = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    lockout_ctrl_if #(.CW(CW)) bus ();

    lockout_ctrl #(
        .MAX_TRIES   (MAX_TRIES),
        .MAX_LOCKOUTS(MAX_LOCKOUTS),
        .ACK_WAIT    (ACK_WAIT),
        .CW          (CW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_rst    = 0;

    // Reference model: the controller's situation described as facts, not encoded states.
    int m_fail, m_lock, m_ack_waited;
    bit m_wait_ack, m_timing, m_alarm, m_fault;
    bit e_grant, e_deny, e_reject;

    // Timer stand-in
    bit t_run, t_drop, t_dead, t_seen;
    int t_left;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fail = 0; m_lock = 0; m_ack_waited = 0;
        m_wait_ack = 0; m_timing = 0; m_alarm = 0; m_fault = 0;
        e_grant = 0; e_deny = 0; e_reject = 0;
    endtask

    task automatic model_step(input bit ev, input bit ok, input bit clr, input bit busy, input bit done);
        e_grant = 0; e_deny = 0; e_reject = 0;
        if (ev && (m_wait_ack || m_timing || m_alarm)) e_reject = 1;
        if (m_alarm) begin
            if (clr) begin
                m_alarm = 0; m_fault = 0; m_fail = 0; m_lock = 0;
            end
        end else if (m_wait_ack) begin
            if (busy) begin
                m_wait_ack = 0; m_timing = 1;
            end else begin
                m_ack_waited++;
                if (m_ack_waited == ACK_WAIT) begin
                    m_wait_ack = 0; m_alarm = 1; m_fault = 1;
                end
            end
        end else if (m_timing) begin
            if (done || !busy) m_timing = 0;
        end else if (ev) begin
            if (ok) begin
                e_grant = 1; m_fail = 0; m_lock = 0;
            end else begin
                e_deny = 1;
                m_fail++;
                if (m_fail == MAX_TRIES) begin
                    m_fail = 0;
                    m_lock = (m_lock + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_lock + 1;
                    if (m_lock >= MAX_LOCKOUTS) m_alarm = 1;
                    else begin
                        m_wait_ack = 1; m_ack_waited = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".timer_start"}, 32'(bus.timer_start), 32'(m_wait_ack));
        chk({where, ".locked"},      32'(bus.locked),      32'(m_wait_ack || m_timing || m_alarm));
        chk({where, ".alarm"},       32'(bus.alarm),       32'(m_alarm));
        chk({where, ".fault"},       32'(bus.fault),       32'(m_fault));
        chk({where, ".grant"},       32'(bus.grant),       32'(e_grant));
        chk({where, ".deny"},        32'(bus.deny),        32'(e_deny));
        chk({where, ".reject"},      32'(bus.reject),      32'(e_reject));
        chk({where, ".fail_cnt"},    32'(bus.fail_cnt),    32'(m_fail));
        chk({where, ".lock_cnt"},    32'(bus.lock_cnt),    32'(m_lock));
    endtask

    // Acknowledges a start request one cycle later unless it plays dead for this lockout.
    task automatic timer_drive();
        bus.timer_done = 1'b0;
        if (!bus.timer_start) t_seen = 0;
        else if (!t_seen) begin
            t_seen = 1;
            t_dead = ($urandom_range(0, 4) == 0);
        end
        if (t_run) begin
            if (t_left > 0) t_left--;
            else begin
                t_run = 0;
                if (t_drop) bus.timer_busy = 1'b0;
                else        bus.timer_done = 1'b1;
            end
        end else begin
            bus.timer_busy = 1'b0;
            if (bus.timer_start && !t_dead) begin
                t_run  = 1;
                t_left = $urandom_range(0, 5);
                t_drop = ($urandom_range(0, 3) == 0);
                bus.timer_busy = 1'b1;
            end
        end
    endtask

    task automatic clear_inputs();
        bus.entry_valid = 1'b0;
        bus.entry_ok    = 1'b0;
        bus.admin_clr   = 1'b0;
        bus.timer_busy  = 1'b0;
        bus.timer_done  = 1'b0;
        t_run = 0; t_seen = 0; t_dead = 0; t_drop = 0; t_left = 0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (bus.timer_start && n_rst < 6 && $urandom_range(0, 3) == 0) begin
                n_rst++;
                rst = 1'b0;
                clear_inputs();
                #1;
                model_reset();
                check_all("async_rst");
                @(negedge clk);
                rst = 1'b1;
            end
            timer_drive();
            bus.entry_valid = 1'($urandom_range(0, 1));
            bus.entry_ok    = ($urandom_range(0, 4) == 0);
            bus.admin_clr   = ($urandom_range(0, 9) == 0);
            @(posedge clk);
            model_step(bus.entry_valid, bus.entry_ok, bus.admin_clr, bus.timer_busy, bus.timer_done);
            #1;
            check_all("run");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
